// File: rtl/prescaler_ctrl_if.sv
// Configuration handshake for prescaler_ctrl: the master offers period/mode/ticks,
// and the prescaler reports when it can take them.
interface prescaler_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CNT_WIDTH-1:0] cfg_period;
  logic                 cfg_oneshot;
  logic [7:0]           cfg_ticks;

  modport master (
    output cfg_valid, cfg_period, cfg_oneshot, cfg_ticks,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_period, cfg_oneshot, cfg_ticks,
    output cfg_ready
  );
endinterface

// File: rtl/prescaler_ctrl.sv
// Programmable prescaler: emits a tick every period+1 cycles, either free-running
// or for a fixed burst of ticks followed by a one-cycle done pulse.
//
// state | meaning
// IDLE  | no valid configuration armed; waits for a config offer
// ARMED | configuration stored; waits for start (config may be replaced)
// RUN   | counting; tick on terminal count, burst mode counts ticks
// DONE  | burst finished; one-cycle done pulse, then IDLE
module prescaler_ctrl #(
  parameter int CNT_WIDTH = 16,
  parameter int OUT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prescaler_ctrl_if.slave      cfg,
  input  logic                 start,
  input  logic                 stop,
  output logic                 tick,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [7:0]           r_tick_cnt;
  logic [CNT_WIDTH-1:0] r_period;
  logic                 r_oneshot;
  logic [7:0]           r_ticks;

  logic                 w_run;
  logic                 w_tick;
  logic                 w_cfg_ready;
  logic                 w_accept;
  logic [7:0]           w_last_tick;

  assign w_run       = (r_state == S_RUN);
  assign w_tick      = w_run && (r_cnt == r_period);
  assign w_cfg_ready = (r_state == S_IDLE) || (r_state == S_ARMED);
  assign w_accept    = cfg.cfg_valid && w_cfg_ready;
  // ticks==0 wraps to 255 here, which gives the 256-tick burst
  assign w_last_tick = r_ticks - 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tick_cnt <= '0;
      r_period   <= '0;
      r_oneshot  <= 1'b0;
      r_ticks    <= '0;
    end else begin
      if (w_accept) begin
        r_period  <= cfg.cfg_period;
        r_oneshot <= cfg.cfg_oneshot;
        r_ticks   <= cfg.cfg_ticks;
      end
      case (r_state)
        S_IDLE: begin
          if (cfg.cfg_valid) r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (!cfg.cfg_valid && start) begin
            r_state    <= S_RUN;
            r_cnt      <= '0;
            r_tick_cnt <= '0;
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_tick) begin
            r_cnt <= '0;
            if (r_oneshot) begin
              r_tick_cnt <= r_tick_cnt + 8'd1;
              if (r_tick_cnt == w_last_tick) r_state <= S_DONE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg.cfg_ready = w_cfg_ready;
  assign tick          = w_tick;
  assign out           = w_run ? r_cnt[CNT_WIDTH-1 -: OUT_WIDTH] : '0;
  assign busy          = w_run || (r_state == S_DONE);
  assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_prescaler_ctrl.sv
// Bench for prescaler_ctrl: a run-cycle-index model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_prescaler_ctrl;

  localparam int CW = 16;
  localparam int OW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic          tick;
  logic [OW-1:0] out;
  logic          busy;
  logic          done;

  int n_tests;
  int n_fail;

  prescaler_ctrl_if #(.CNT_WIDTH(CW)) cif ();

  prescaler_ctrl #(.CNT_WIDTH(CW), .OUT_WIDTH(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg   (cif.slave),
    .start (start),
    .stop  (stop),
    .tick  (tick),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks phase and the 1-based index of the current RUN cycle.
  // Tick happens when k is a multiple of period+1; a burst ends after N ticks.
  localparam int M_IDLE = 0, M_ARMED = 1, M_RUN = 2, M_DONE = 3;
  int     m_st;
  longint m_k;
  longint m_p1;
  bit     m_one;
  longint m_n;
  bit     m_valid = 1'b0;

  function automatic bit m_tick();
    return (m_st == M_RUN) && ((m_k % m_p1) == 0);
  endfunction

  function automatic int m_out();
    if (m_st != M_RUN) return 0;
    return int'(((m_k - 1) % m_p1) >> (CW - OW));
  endfunction

  always @(posedge clk) begin
    bit t;
    t = m_tick();
    if (!rst_n) begin
      m_st = M_IDLE; m_p1 = 1; m_one = 1'b0; m_n = 256; m_k = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (cif.cfg_valid && (m_st == M_IDLE || m_st == M_ARMED)) begin
        m_p1  = longint'(cif.cfg_period) + 1;
        m_one = cif.cfg_oneshot;
        m_n   = (cif.cfg_ticks == 8'd0) ? 256 : longint'(cif.cfg_ticks);
      end
      case (m_st)
        M_IDLE:  if (cif.cfg_valid) m_st = M_ARMED;
        M_ARMED: begin
          if (stop) m_st = M_IDLE;
          else if (!cif.cfg_valid && start) begin m_st = M_RUN; m_k = 1; end
        end
        M_RUN: begin
          if (stop) m_st = M_IDLE;
          else if (t && m_one && (m_k / m_p1) == m_n) m_st = M_DONE;
          else m_k = m_k + 1;
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("tick",      32'(tick),          32'(m_tick()));
      chk("out",       32'(out),           32'(m_out()));
      chk("busy",      32'(busy),          32'(m_st == M_RUN || m_st == M_DONE));
      chk("done",      32'(done),          32'(m_st == M_DONE));
      chk("cfg_ready", 32'(cif.cfg_ready), 32'(m_st == M_IDLE || m_st == M_ARMED));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [CW-1:0] p, input logic o, input logic [7:0] t);
    cif.cfg_valid = 1'b1; cif.cfg_period = p; cif.cfg_oneshot = o; cif.cfg_ticks = t;
    step();
    cif.cfg_valid = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt, nd;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    cif.cfg_valid = 1'b0; cif.cfg_period = '0; cif.cfg_oneshot = 1'b0; cif.cfg_ticks = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out",  32'(out),  32'd0);
    chk("rst_ready", 32'(cif.cfg_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Periodic, period=3: ticks on RUN cycles 4, 8, 12
    cfg(16'd3, 1'b0, 8'd0);
    go();
    for (int c = 1; c <= 12; c++) begin
      chk("per_tick", 32'(tick), 32'((c % 4) == 0));
      chk("per_busy", 32'(busy), 32'd1);
      step();
    end
    halt();
    chk("per_stop_busy", 32'(busy), 32'd0);

    // Burst, period=1, ticks=3: ticks 2,4,6; done 7; idle 8
    cfg(16'd1, 1'b1, 8'd3);
    go();
    for (int c = 1; c <= 8; c++) begin
      chk("bur_tick", 32'(tick), 32'(c == 2 || c == 4 || c == 6));
      chk("bur_done", 32'(done), 32'(c == 7));
      chk("bur_busy", 32'(busy), 32'(c <= 7));
      step();
    end

    // period=0, ticks=0: 256 consecutive ticks then a single done
    cfg(16'd0, 1'b1, 8'd0);
    go();
    nt = 0; nd = 0;
    for (int c = 0; c < 300; c++) begin
      nt += int'(tick);
      nd += int'(done);
      step();
    end
    chk("b256_ticks", 32'(nt), 32'd256);
    chk("b256_done",  32'(nd), 32'd1);

    // Stop on the final burst tick: tick still emitted, no done
    cfg(16'd1, 1'b1, 8'd2);
    go();
    step(); step(); step();
    stop = 1'b1;
    chk("stopfin_tick", 32'(tick), 32'd1);
    step();
    stop = 1'b0;
    chk("stopfin_done",  32'(done), 32'd0);
    chk("stopfin_busy",  32'(busy), 32'd0);
    chk("stopfin_ready", 32'(cif.cfg_ready), 32'd1);
    step();
    chk("stopfin_done2", 32'(done), 32'd0);

    // Reconfigure in ARMED; start together with cfg_valid is ignored
    cfg(16'd5, 1'b0, 8'd0);
    start = 1'b1;
    cfg(16'd2, 1'b0, 8'd0);
    start = 1'b0;
    chk("cfgstart_busy", 32'(busy), 32'd0);
    go();
    for (int c = 1; c <= 6; c++) begin
      chk("recfg_tick", 32'(tick), 32'((c % 3) == 0));
      step();
    end
    halt();
    go();
    chk("idle_start", 32'(busy), 32'd0);

    // Stop in ARMED returns to IDLE; later start ignored
    cfg(16'd2, 1'b0, 8'd0);
    halt();
    go();
    chk("armed_stop", 32'(busy), 32'd0);

    // Reset mid-RUN
    cfg(16'd1, 1'b1, 8'd5);
    go();
    step(); step();
    rst_n = 1'b0;
    step();
    chk("mrst_busy",  32'(busy), 32'd0);
    chk("mrst_done",  32'(done), 32'd0);
    chk("mrst_tick",  32'(tick), 32'd0);
    chk("mrst_ready", 32'(cif.cfg_ready), 32'd1);
    rst_n = 1'b1;
    step();
    chk("mrst_done2", 32'(done), 32'd0);
    go();
    chk("mrst_nocfg", 32'(busy), 32'd0);

    // period=all-ones: first tick on RUN cycle 65536
    cfg(16'hFFFF, 1'b0, 8'd0);
    go();
    repeat (65534) step();
    chk("max_pre_tick", 32'(tick), 32'd0);
    chk("max_pre_out",  32'(out),  32'd15);
    step();
    chk("max_tick", 32'(tick), 32'd1);
    chk("max_out",  32'(out),  32'd15);
    step();
    chk("max_wrap_out",  32'(out),  32'd0);
    chk("max_wrap_tick", 32'(tick), 32'd0);
    halt();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prescaler_ctrl.md
PRESCALER_CTRL -- requirements
Module: prescaler_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 16, giving the period counter width in bits.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 4, giving the phase output width; OUT_WIDTH <= CNT_WIDTH.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port cfg_valid  input  1  configuration offer.
REQ-006 The block SHALL have port cfg_ready  output  1  configuration may be accepted.
REQ-007 The block SHALL have port cfg_period  input  CNT_WIDTH  terminal count; tick period = cfg_period+1 cycles.
REQ-008 The block SHALL have port cfg_oneshot  input  1  1 = burst mode, 0 = periodic mode.
REQ-009 The block SHALL have port cfg_ticks  input  8  burst length in ticks; 0 means 256.
REQ-010 The block SHALL have port start  input  1  start request.
REQ-011 The block SHALL have port stop  input  1  abort request.
REQ-012 The block SHALL have port tick  output  1  one-cycle period strobe.
REQ-013 The block SHALL have port out  output  OUT_WIDTH  counter phase MSBs.
REQ-014 The block SHALL have port busy  output  1  counting in progress.
REQ-015 The block SHALL have port done  output  1  one-cycle burst-complete pulse.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, ARMED, RUN, DONE.
REQ-017 cfg_ready SHALL be 1 in IDLE and ARMED only; a configuration is accepted on any edge with cfg_valid & cfg_ready.
REQ-018 On acceptance, period, mode and ticks SHALL be registered and the FSM SHALL enter ARMED; acceptance in ARMED overwrites the stored configuration.
REQ-019 start SHALL be honoured only in ARMED with cfg_valid=0 and stop=0; the next state is RUN with cnt=0 and tick_cnt=0.
REQ-020 start SHALL be ignored in IDLE, RUN and DONE.
REQ-021 In RUN, cnt SHALL increment by 1 each cycle and wrap to 0 on the edge after cnt==period; no other wrap point.
REQ-022 tick SHALL equal (state==RUN) && (cnt==period), decoded from registers only, with no input-to-output path.
REQ-023 Tick cadence: the first tick is in the (period+1)th RUN cycle and repeats every period+1 cycles. period=0 gives tick every RUN cycle.
REQ-024 out SHALL equal cnt[CNT_WIDTH-1 -: OUT_WIDTH] in RUN and 0 in all other states.
REQ-025 In burst mode, tick_cnt SHALL increment on each tick; on the tick where tick_cnt==ticks-1 (mod 256), the next state is DONE.
REQ-026 In periodic mode, RUN SHALL continue until stop or reset.
REQ-027 DONE SHALL last exactly one cycle with done=1, then go to IDLE; the stored configuration is retained.
REQ-028 stop SHALL have priority over completion and start: stop in RUN or ARMED goes to IDLE next cycle with no done; a tick decoded in the stop cycle is still emitted.
REQ-029 stop in IDLE or DONE SHALL have no effect.
REQ-030 busy SHALL be 1 in RUN and DONE, 0 otherwise.

Reset
REQ-031 When rst_n=0 at an edge, the block SHALL go to IDLE and clear cnt, tick_cnt and the stored config (period=0, oneshot=0, ticks=0).
REQ-032 During reset, tick, done, busy and out SHALL be 0 and cfg_ready SHALL be 1 from the first post-reset cycle.
REQ-033 Reset during RUN or DONE SHALL abort without a done pulse.

Verification
REQ-034 Periodic: cfg period=3, oneshot=0, then start -> tick in RUN cycles 4, 8, 12...; out follows cnt MSBs; busy=1 throughout.
REQ-035 Burst: period=1, ticks=3 -> ticks in RUN cycles 2, 4, 6; done=1 in cycle 7; IDLE in cycle 8; busy 0 after done.
REQ-036 Boundary: period=0, ticks=0 -> 256 consecutive ticks, then a single done pulse; also period=all-ones -> first tick after 2^CNT_WIDTH cycles.
REQ-037 Priority: stop asserted on the final burst tick -> tick emitted, no done, IDLE next cycle; start with cfg_valid in ARMED -> start ignored, new config held.
REQ-038 Reconfigure in ARMED: accept period=5, then period=2, then start -> ticks every 3 cycles; start in IDLE -> no effect.
REQ-039 Reset mid-RUN: rst_n=0 for 1 cycle -> all outputs 0, state IDLE, no done, cfg_ready=1 next cycle.
